// File: rtl/oc_serial_rx_pkg.sv
// Shared definitions for the open-collector serial link: state encodings and
// default framing parameters, also used by the transmitter side.
package oc_serial_rx_pkg;

  localparam int DEF_DIV   = 16;
  localparam int DEF_NBITS = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_WAITHI = 3'd4
  } rx_state_t;

endpackage

// File: rtl/oc_line_sync.sv
// Conditions the wired-AND line (anything but a hard 0 reads as released)
// and brings it into the clk domain through two flops that clear to idle-high.
module oc_line_sync (
  input  logic clk,
  input  logic clr_n,
  input  logic line,
  output logic s
);

  logic lin;
  logic meta_p0;

  assign lin = (line === 1'b0) ? 1'b0 : 1'b1;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      meta_p0 <= 1'b1;
      s       <= 1'b1;
    end else begin
      meta_p0 <= lin;
      s       <= meta_p0;
    end
  end

endmodule

// File: rtl/oc_serial_rx.sv
// Open-collector serial receiver: start-bit qualify at mid-bit, LSB-first
// shift of NBITS data bits, stop-bit check, one-cycle valid on a good frame.
module oc_serial_rx
  import oc_serial_rx_pkg::*;
#(
  parameter int DIV   = DEF_DIV,
  parameter int NBITS = DEF_NBITS
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             line,
  output logic [NBITS-1:0] data,
  output logic             valid,
  output logic             ferr,
  output logic             busy
);

  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_END = CW'(DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  logic            s;
  rx_state_t       state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [BW-1:0]   bitc, bitc_nxt;
  logic [NBITS-1:0] sr;
  logic [NBITS:0]  sr_ext;
  logic            shift_en, load, set_ferr;

  oc_line_sync u_sync (
    .clk   (clk),
    .clr_n (clr_n),
    .line  (line),
    .s     (s)
  );

  assign busy   = (state != S_IDLE);
  assign sr_ext = {s, sr};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bitc_nxt  = bitc;
    shift_en  = 1'b0;
    load      = 1'b0;
    set_ferr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!s) begin
          state_nxt = S_START;
          cnt_nxt   = '0;
        end
      end
      S_START: begin
        // A start bit that has gone high again by mid-bit was a glitch.
        if (cnt == HALF_END) begin
          cnt_nxt   = '0;
          bitc_nxt  = '0;
          state_nxt = s ? S_IDLE : S_DATA;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt == FULL_END) begin
          cnt_nxt  = '0;
          shift_en = 1'b1;
          if (bitc == LAST_BIT) begin
            bitc_nxt  = '0;
            state_nxt = S_STOP;
          end else begin
            bitc_nxt = bitc + BW'(1);
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt == FULL_END) begin
          cnt_nxt = '0;
          if (s) begin
            load      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            set_ferr  = 1'b1;
            state_nxt = S_WAITHI;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_WAITHI: begin
        if (s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      bitc  <= '0;
      data  <= '0;
      valid <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      bitc  <= bitc_nxt;
      valid <= load;
      if (load) begin
        data <= sr;
        ferr <= 1'b0;
      end else if (set_ferr) begin
        ferr <= 1'b1;
      end
    end
  end

  // Shift register is pure datapath; a partial frame is never presented.
  always_ff @(posedge clk) begin
    if (shift_en) sr <= sr_ext[NBITS:1];
  end

endmodule

// File: tb/tb_oc_serial_rx.sv
// Bench for oc_serial_rx: OC driver with pullup on the net, directed frames
// plus random frames scored against a frame-level timing/data model.
module tb_oc_serial_rx;

  localparam int DIV   = 16;
  localparam int NBITS = 8;
  // Driver sets the line low right after edge n; the first sampling edge is n+1.
  localparam int LAT   = 1 + 2 + DIV / 2 + (NBITS + 1) * DIV;

  logic clk = 1'b0;
  logic clr_n;
  logic drv_a;
  wire  line_net;
  logic [NBITS-1:0] data;
  logic valid, ferr, busy;

  assign line_net = drv_a ? 1'b0 : 1'bz;
  pullup (line_net);

  oc_serial_rx #(.DIV(DIV), .NBITS(NBITS)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .line  (line_net),
    .data  (data),
    .valid (valid),
    .ferr  (ferr),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    bit         good;
    logic [7:0] d;
  } ev_t;
  ev_t evq[$];

  logic [7:0] exp_data  = 8'h00;
  bit         exp_ferr  = 1'b0;
  bit         exp_valid = 1'b0;
  int         last_vcyc = -1000;
  int         prev_vcyc = -1000;

  // Frame-level model: each sent frame resolves at a fixed cycle.
  always @(negedge clk) begin
    exp_valid = 1'b0;
    if (!clr_n) begin
      exp_data = 8'h00;
      exp_ferr = 1'b0;
      evq.delete();
    end else begin
      while (evq.size() > 0 && evq[0].cyc == cyc) begin
        if (evq[0].good) begin
          exp_valid = 1'b1;
          exp_data  = evq[0].d;
          exp_ferr  = 1'b0;
        end else begin
          exp_ferr = 1'b1;
        end
        void'(evq.pop_front());
      end
    end
    chk("outs", 32'({valid, ferr, data}), 32'({exp_valid, exp_ferr, exp_data}));
    if (valid) begin
      chk("busy_on_valid", 32'(busy), 0);
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
    end
  end

  task automatic hold(input bit low, input int n);
    drv_a = low;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good);
    ev_t e;
    e.cyc  = cyc + LAT;
    e.good = good;
    e.d    = b;
    evq.push_back(e);
    hold(1'b1, DIV);
    for (int i = 0; i < NBITS; i++) hold(~b[i], DIV);
    hold(~good, DIV);
  endtask

  initial begin
    int  n0;
    int  gap;
    bit  good;
    bit  prev_bad;

    clr_n = 1'b0;
    drv_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'({data, valid, ferr, busy}), 0);
    clr_n = 1'b1;
    hold(1'b0, 20);

    // Single good frame
    send_frame(8'hA5, 1'b1);
    chk("t1_data", 32'(data), 32'h A5);
    chk("t1_busy_idle", 32'(busy), 0);
    hold(1'b0, 10);

    // Short low glitch must abort at mid-bit
    n0 = cyc;
    hold(1'b1, 4);
    drv_a = 1'b0;
    @(negedge clk);
    chk("t2_busy_start", 32'(busy), 1);
    while (cyc < n0 + 12) @(negedge clk);
    chk("t2_busy_abort", 32'(busy), 0);
    @(posedge clk);
    #1;
    hold(1'b0, 10);

    // Bad stop bit followed by a stuck-low bus
    send_frame(8'h3C, 1'b0);
    hold(1'b1, 40);
    chk("t3_busy_low", 32'(busy), 1);
    chk("t3_ferr", 32'(ferr), 1);
    chk("t3_data_kept", 32'(data), 32'h A5);
    hold(1'b0, 5);
    chk("t3_busy_release", 32'(busy), 0);
    send_frame(8'h81, 1'b1);
    chk("t3_data_good", 32'(data), 32'h 81);
    chk("t3_ferr_clear", 32'(ferr), 0);

    // Long released line
    hold(1'b0, 500);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_data", 32'(data), 32'h 81);

    // Asynchronous clear in the middle of a frame of 0xFF
    hold(1'b1, DIV);
    hold(1'b0, 3 * DIV + 10);
    #2;
    clr_n = 1'b0;
    #1;
    chk("t5_async_clear", 32'({data, valid, ferr, busy}), 0);
    repeat (3) @(posedge clk);
    #1;
    clr_n = 1'b1;
    hold(1'b0, 40);
    chk("t5_idle_after_clear", 32'(busy), 0);
    send_frame(8'h55, 1'b1);
    chk("t5_data", 32'(data), 32'h 55);

    // Back-to-back frames with no idle gap
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    chk("t6_gap", 32'(last_vcyc - prev_vcyc), (NBITS + 2) * DIV);
    chk("t6_data", 32'(data), 32'h 34);

    // Random frames, gaps and occasional framing errors
    prev_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      gap = $urandom_range(0, 20);
      if (prev_bad && gap < 4) gap = 4;
      if (gap > 0) hold(1'b0, gap);
      good = ($urandom_range(0, 7) != 0);
      send_frame(8'($urandom), good);
      if (!good) begin
        gap = $urandom_range(0, 10);
        if (gap > 0) hold(1'b1, gap);
      end
      prev_bad = !good;
    end
    hold(1'b0, 20);
    chk("final_busy", 32'(busy), 0);
    chk("final_pending", 32'(evq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
